riscv_run_ctrl: RTL and testbench

//  Sequences the single-cycle core through one run: load program -> release reset -> run -> dump dmem.

---
 rtl/riscv_run_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_riscv_run_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_run_ctrl.sv
// Run controller for the single-cycle core: loads a program into imem while
// the core is held in reset, releases and runs the core until halt or a cycle
// timeout, then streams the first DUMP_WORDS dmem words out over valid/ready.
//
// Handshakes: a word moves on any rising edge where valid and ready are both
// high. ld_ready_o is high for the whole LOAD state. dump_valid_o, once high,
// holds itself and dump_data_o steady until the edge that sees dump_ready_i;
// dump_ready_i has no effect while dump_valid_o is low.
module riscv_run_ctrl #(
   parameter int DW         = 32,
   parameter int NO_OF_REGS = 256,
   parameter int AW         = $clog2(NO_OF_REGS),
   parameter int RST_CYCLES = 2,
   parameter int MAX_CYCLES = 500,
   parameter int DUMP_WORDS = 21,
   parameter int CW         = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic          ld_valid_i,
   output logic          ld_ready_o,
   input  logic [DW-1:0] ld_data_i,
   input  logic          ld_last_i,
   output logic          imem_we_o,
   output logic [AW-1:0] imem_addr_o,
   output logic [DW-1:0] imem_wdata_o,
   output logic          core_rst_o,
   input  logic          halt_i,
   output logic [AW-1:0] dmem_rd_addr_o,
   input  logic [DW-1:0] dmem_rd_data_i,
   output logic          dump_valid_o,
   input  logic          dump_ready_i,
   output logic [DW-1:0] dump_data_o,
   output logic [CW-1:0] cycles_o,
   output logic          timeout_o,
   output logic          done_o
);

   // Dump index must be able to reach DUMP_WORDS, which may equal NO_OF_REGS.
   localparam int IW = AW + 1;
   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RELEASE,
      S_RUN,
      S_DUMP_RD,
      S_DUMP_WAIT,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [RW-1:0] rel_q, rel_d;
   logic [CW-1:0] cycles_q, cycles_d;
   logic          timeout_q, timeout_d;
   logic          done_q, done_d;
   logic          core_rst_q, core_rst_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          dump_valid_q, dump_valid_d;
   logic [DW-1:0] dump_data_q, dump_data_d;

   assign ld_ready_o     = (state_q == S_LOAD);
   assign imem_we_o      = ld_valid_i & ld_ready_o;
   assign imem_addr_o    = addr_q;
   assign imem_wdata_o   = ld_data_i;
   assign core_rst_o     = core_rst_q;
   assign dmem_rd_addr_o = idx_q[AW-1:0];
   assign dump_valid_o   = dump_valid_q;
   assign dump_data_o    = dump_data_q;
   assign cycles_o       = cycles_q;
   assign timeout_o      = timeout_q;
   assign done_o         = done_q;

   // Next-state and next-output logic for the run sequence.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      rel_d        = rel_q;
      cycles_d     = cycles_q;
      timeout_d    = timeout_q;
      done_d       = done_q;
      core_rst_d   = core_rst_q;
      idx_d        = idx_q;
      dump_valid_d = dump_valid_q;
      dump_data_d  = dump_data_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d    = S_LOAD;
               addr_d     = '0;
               cycles_d   = '0;
               timeout_d  = 1'b0;
               done_d     = 1'b0;
               core_rst_d = 1'b1;
            end
         end
         S_LOAD: begin
            if (imem_we_o) begin
               // The address saturates at the last word; that write ends the load.
               if (addr_q != AW'(NO_OF_REGS - 1)) addr_d = addr_q + 1'b1;
               if (ld_last_i || (addr_q == AW'(NO_OF_REGS - 1))) begin
                  state_d = S_RELEASE;
                  rel_d   = '0;
               end
            end
         end
         S_RELEASE: begin
            if (rel_q == RW'(RST_CYCLES - 1)) begin
               state_d    = S_RUN;
               core_rst_d = 1'b0;
            end else begin
               rel_d = rel_q + 1'b1;
            end
         end
         S_RUN: begin
            // Halt takes priority over the timeout on the same edge.
            if (halt_i) begin
               state_d    = S_DUMP_RD;
               timeout_d  = 1'b0;
               core_rst_d = 1'b1;
               idx_d      = '0;
            end else if (cycles_q == CW'(MAX_CYCLES - 1)) begin
               state_d    = S_DUMP_RD;
               cycles_d   = CW'(MAX_CYCLES);
               timeout_d  = 1'b1;
               core_rst_d = 1'b1;
               idx_d      = '0;
            end else begin
               cycles_d = cycles_q + 1'b1;
            end
         end
         S_DUMP_RD: begin
            state_d = S_DUMP_WAIT;
         end
         S_DUMP_WAIT: begin
            // First cycle captures the read data; later cycles wait for ready.
            if (!dump_valid_q) begin
               dump_data_d  = dmem_rd_data_i;
               dump_valid_d = 1'b1;
            end else if (dump_ready_i) begin
               dump_valid_d = 1'b0;
               idx_d        = idx_q + 1'b1;
               if (idx_q == IW'(DUMP_WORDS - 1)) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_DUMP_RD;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         rel_q        <= '0;
         cycles_q     <= '0;
         timeout_q    <= 1'b0;
         done_q       <= 1'b0;
         core_rst_q   <= 1'b1;
         idx_q        <= '0;
         dump_valid_q <= 1'b0;
         dump_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         rel_q        <= rel_d;
         cycles_q     <= cycles_d;
         timeout_q    <= timeout_d;
         done_q       <= done_d;
         core_rst_q   <= core_rst_d;
         idx_q        <= idx_d;
         dump_valid_q <= dump_valid_d;
         dump_data_q  <= dump_data_d;
      end
   end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Directed bench for riscv_run_ctrl: program load, release timing, halt and
// timeout runs, dump back-pressure and mid-run reset.
module tb_riscv_run_ctrl;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int CW = 32;
   localparam int DUMP_WORDS = 21;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          start_i = 1'b0;
   logic          ld_valid_i = 1'b0;
   logic          ld_ready_o;
   logic [DW-1:0] ld_data_i = '0;
   logic          ld_last_i = 1'b0;
   logic          imem_we_o;
   logic [AW-1:0] imem_addr_o;
   logic [DW-1:0] imem_wdata_o;
   logic          core_rst_o;
   logic          halt_i = 1'b0;
   logic [AW-1:0] dmem_rd_addr_o;
   logic [DW-1:0] dmem_rd_data_i;
   logic          dump_valid_o;
   logic          dump_ready_i = 1'b0;
   logic [DW-1:0] dump_data_o;
   logic [CW-1:0] cycles_o;
   logic          timeout_o;
   logic          done_o;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] imem_m [256];
   logic [DW-1:0] dmem_m [256];
   int            wr_cnt = 0;
   logic [DW-1:0] exp_q [$];

   riscv_run_ctrl dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .start_i        (start_i),
      .ld_valid_i     (ld_valid_i),
      .ld_ready_o     (ld_ready_o),
      .ld_data_i      (ld_data_i),
      .ld_last_i      (ld_last_i),
      .imem_we_o      (imem_we_o),
      .imem_addr_o    (imem_addr_o),
      .imem_wdata_o   (imem_wdata_o),
      .core_rst_o     (core_rst_o),
      .halt_i         (halt_i),
      .dmem_rd_addr_o (dmem_rd_addr_o),
      .dmem_rd_data_i (dmem_rd_data_i),
      .dump_valid_o   (dump_valid_o),
      .dump_ready_i   (dump_ready_i),
      .dump_data_o    (dump_data_o),
      .cycles_o       (cycles_o),
      .timeout_o      (timeout_o),
      .done_o         (done_o)
   );

   // Clock and reset block.
   always #5 clk_i = ~clk_i;

   // Instruction memory model: records every write.
   always @(posedge clk_i) begin
      if (imem_we_o) begin
         imem_m[imem_addr_o] <= imem_wdata_o;
         wr_cnt <= wr_cnt + 1;
      end
   end

   // Data memory model: synchronous read, data one cycle after address.
   always @(posedge clk_i) dmem_rd_data_i <= dmem_m[dmem_rd_addr_o];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   // Stream n words back to back, last flagged on the final one.
   task automatic load_burst(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                             input logic [DW-1:0] w2, input logic [DW-1:0] w3,
                             input int n);
      logic [DW-1:0] w [4];
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      for (int i = 0; i < n; i++) begin
         chk("ld_ready_in_load", ld_ready_o, 1'b1);
         ld_valid_i = 1'b1;
         ld_data_i  = w[i];
         ld_last_i  = (i == n - 1);
         tick();
      end
      ld_valid_i = 1'b0;
      ld_last_i  = 1'b0;
   endtask

   // Drain the dump, optionally stalling 3 valid cycles on one word.
   task automatic dump_all(input int stall_word);
      int idx = 0;
      int stall = 0;
      int budget = 0;
      logic [DW-1:0] exp;
      for (int i = 0; i < DUMP_WORDS; i++) exp_q.push_back(dmem_m[i]);
      while (idx < DUMP_WORDS && budget < 400) begin
         tick();
         budget++;
         if (dump_valid_o) begin
            exp = exp_q[0];
            if (idx == stall_word && stall < 3) begin
               dump_ready_i = 1'b0;
               chk("dump_stall_data", dump_data_o, exp);
               stall++;
            end else begin
               dump_ready_i = 1'b1;
               chk("dump_data", dump_data_o, exp);
               void'(exp_q.pop_front());
               idx++;
            end
         end else begin
            dump_ready_i = 1'b0;
         end
      end
      chk("dump_count", idx, DUMP_WORDS);
      tick();
      dump_ready_i = 1'b0;
      chk("done", done_o, 1'b1);
      chk("dump_valid_after", dump_valid_o, 1'b0);
      chk("core_rst_done", core_rst_o, 1'b1);
      exp_q.delete();
   endtask

   initial begin
      int base;
      int n;
      for (int i = 0; i < 256; i++) dmem_m[i] = 32'hC0DE_0000 + i * 32'h0001_0003;

      // Reset state.
      rst_i = 1'b1;
      tick(); tick();
      rst_i = 1'b0;
      chk("rst_core_rst", core_rst_o, 1'b1);
      chk("rst_ld_ready", ld_ready_o, 1'b0);
      chk("rst_cycles", cycles_o, 0);
      chk("rst_timeout", timeout_o, 1'b0);
      chk("rst_done", done_o, 1'b0);
      chk("rst_dump_valid", dump_valid_o, 1'b0);
      tick();
      chk("idle_hold", ld_ready_o, 1'b0);

      // Test 1: four-word load and release timing.
      base = wr_cnt;
      do_start();
      load_burst(32'h00500093, 32'h00a00113, 32'h002081b3, 32'h00000073, 4);
      chk("t1_wr_cnt", wr_cnt - base, 4);
      chk("t1_imem0", imem_m[0], 32'h00500093);
      chk("t1_imem1", imem_m[1], 32'h00a00113);
      chk("t1_imem2", imem_m[2], 32'h002081b3);
      chk("t1_imem3", imem_m[3], 32'h00000073);
      chk("t1_ready_off", ld_ready_o, 1'b0);
      chk("t1_rel1", core_rst_o, 1'b1);
      tick();
      chk("t1_rel2", core_rst_o, 1'b1);
      tick();
      chk("t1_run_rst", core_rst_o, 1'b0);
      chk("t1_run_cyc0", cycles_o, 0);

      // Test 3 + 5: halt at cycles 10, stalled dump on word 5.
      for (int i = 0; i < 10; i++) begin
         start_i = (i == 4);
         tick();
      end
      start_i = 1'b0;
      chk("t3_cycles_pre", cycles_o, 10);
      chk("t3_start_ignored", ld_ready_o, 1'b0);
      halt_i = 1'b1;
      tick();
      halt_i = 1'b0;
      chk("t3_cycles", cycles_o, 10);
      chk("t3_timeout", timeout_o, 1'b0);
      chk("t3_core_rst", core_rst_o, 1'b1);
      dump_all(5);
      chk("t3_cycles_held", cycles_o, 10);

      // Test 2: gappy load, then Test 4: timeout run.
      base = wr_cnt;
      do_start();
      chk("t2_done_clr", done_o, 1'b0);
      chk("t2_cycles_clr", cycles_o, 0);
      chk("t2_ready", ld_ready_o, 1'b1);
      ld_valid_i = 1'b1; ld_data_i = 32'h1111_1111; tick();
      chk("t2_ready_a", ld_ready_o, 1'b1);
      ld_valid_i = 1'b0; ld_data_i = 32'hDEAD_BEEF; tick();
      chk("t2_ready_b", ld_ready_o, 1'b1);
      tick();
      chk("t2_ready_c", ld_ready_o, 1'b1);
      ld_valid_i = 1'b1; ld_data_i = 32'h2222_2222; tick();
      chk("t2_ready_d", ld_ready_o, 1'b1);
      ld_data_i = 32'h3333_3333; ld_last_i = 1'b1; tick();
      ld_valid_i = 1'b0; ld_last_i = 1'b0;
      chk("t2_wr_cnt", wr_cnt - base, 3);
      chk("t2_imem0", imem_m[0], 32'h1111_1111);
      chk("t2_imem1", imem_m[1], 32'h2222_2222);
      chk("t2_imem2", imem_m[2], 32'h3333_3333);
      chk("t2_imem3_kept", imem_m[3], 32'h00000073);
      tick(); tick();
      chk("t4_run", core_rst_o, 1'b0);
      n = 0;
      while (timeout_o == 1'b0 && n < 700) begin
         tick();
         n++;
      end
      chk("t4_run_edges", n, 500);
      chk("t4_cycles", cycles_o, 500);
      chk("t4_timeout", timeout_o, 1'b1);
      dump_all(-1);
      chk("t4_timeout_held", timeout_o, 1'b1);

      // Test 6: reset mid-run, then clean rerun.
      do_start();
      load_burst(32'h00000013, 32'h00000073, 32'h0, 32'h0, 2);
      tick(); tick();
      for (int i = 0; i < 5; i++) tick();
      chk("t6_cycles_pre", cycles_o, 5);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("t6_core_rst", core_rst_o, 1'b1);
      chk("t6_cycles", cycles_o, 0);
      chk("t6_ready", ld_ready_o, 1'b0);
      chk("t6_done", done_o, 1'b0);
      do_start();
      load_burst(32'h00100093, 32'h00000073, 32'h0, 32'h0, 2);
      chk("t6_imem0", imem_m[0], 32'h00100093);
      tick(); tick();
      chk("t6_run", core_rst_o, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      halt_i = 1'b1;
      tick();
      halt_i = 1'b0;
      chk("t6_cycles_halt", cycles_o, 3);
      chk("t6_timeout", timeout_o, 1'b0);
      dump_all(-1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
